// File: rtl/grom_mem_arbiter.sv
// Two-master arbiter for the single-port ram_memory: round-robin grant, burst cap,
// and a CPU lock that holds the bus across read-modify-write sequences.
module grom_mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_we,
    output logic                  m1_gnt,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_memreq,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            rr_ptr;
    logic [CW-1:0]   burst_cnt;
    logic            cap_hit;
    logic            xfer0;
    logic            xfer1;

    // Handshake: a master holds req/addr/wdata/we stable; a transfer happens in every
    // cycle where its gnt and req are both high. rvalid follows a read transfer by one cycle.
    assign m0_gnt   = (state == OWN0);
    assign m1_gnt   = (state == OWN1);
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;
    assign cap_hit  = (burst_cnt == CW'(MAX_BURST - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) state_next = rr_ptr ? OWN1 : OWN0;
                else if (m0_req)      state_next = OWN0;
                else if (m1_req)      state_next = OWN1;
                else                  state_next = IDLE;
            end
            OWN0: begin
                if (!m0_req)                           state_next = m1_req ? OWN1 : IDLE;
                else if (cap_hit && m1_req && !m0_lock) state_next = OWN1;
                else                                   state_next = OWN0;
            end
            OWN1: begin
                if (!m1_req)               state_next = m0_req ? OWN0 : IDLE;
                else if (cap_hit && m0_req) state_next = OWN0;
                else                       state_next = OWN1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: memory port is driven only by a transferring owner, never during reset
    always_comb begin
        xfer0      = !reset && (state == OWN0) && m0_req;
        xfer1      = !reset && (state == OWN1) && m1_req;
        mem_memreq = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (xfer0) begin
            mem_memreq = 1'b1;
            mem_we     = m0_we;
            mem_addr   = m0_addr;
            mem_wdata  = m0_wdata;
        end else if (xfer1) begin
            mem_memreq = 1'b1;
            mem_we     = m1_we;
            mem_addr   = m1_addr;
            mem_wdata  = m1_wdata;
        end
    end

    // Fairness bookkeeping and read-valid pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= xfer0 && !m0_we;
            m1_rvalid <= xfer1 && !m1_we;
            if (state_next != state && state_next == OWN0) begin
                rr_ptr    <= 1'b1;
                burst_cnt <= '0;
            end else if (state_next != state && state_next == OWN1) begin
                rr_ptr    <= 1'b0;
                burst_cnt <= '0;
            end else if ((xfer0 || xfer1) && !cap_hit) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_grom_mem_arbiter.sv
// Directed bench for grom_mem_arbiter: per-cycle vector table plus hand-written
// sequences for write/read-back, CPU lock, and reset during a read.
module tb_grom_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_memreq;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic          rst;
        logic          req0;
        logic          req1;
        logic          gnt0;
        logic          gnt1;
        logic          memreq;
        logic [AW-1:0] addr;
        logic          rv0;
        logic          rv1;
    } vec_t;

    vec_t vecs [18];

    grom_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_memreq(mem_memreq), .mem_rdata(mem_rdata)
    );

    // Clock and a behavioural ram_memory with one-cycle registered read
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memreq) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 12'h010; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 12'h020; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        mem_rdata = '0;
        reset     = 1'b1;
        idle_inputs();

        //                rst  req0  req1  gnt0  gnt1  mreq  addr     rv0   rv1
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h020, 1'b0, 1'b0};

        // Table: reset, alternating 4-transfer bursts, owner drop, idle, round-robin tie
        for (int i = 0; i < 18; i++) begin
            reset  = vecs[i].rst;
            m0_req = vecs[i].req0;
            m1_req = vecs[i].req1;
            @(negedge clk);
            check($sformatf("v%0d gnt0", i),   {31'b0, m0_gnt},     {31'b0, vecs[i].gnt0});
            check($sformatf("v%0d gnt1", i),   {31'b0, m1_gnt},     {31'b0, vecs[i].gnt1});
            check($sformatf("v%0d memreq", i), {31'b0, mem_memreq}, {31'b0, vecs[i].memreq});
            check($sformatf("v%0d we", i),     {31'b0, mem_we},     32'd0);
            check($sformatf("v%0d addr", i),   {20'b0, mem_addr},   {20'b0, vecs[i].addr});
            check($sformatf("v%0d rv0", i),    {31'b0, m0_rvalid},  {31'b0, vecs[i].rv0});
            check($sformatf("v%0d rv1", i),    {31'b0, m1_rvalid},  {31'b0, vecs[i].rv1});
            step();
        end

        // Write 0x123 <= 0xA5, then read it back
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h123; m0_wdata = 8'hA5;
        step();
        @(negedge clk);
        check("wr gnt0",   {31'b0, m0_gnt},     32'd1);
        check("wr memreq", {31'b0, mem_memreq}, 32'd1);
        check("wr we",     {31'b0, mem_we},     32'd1);
        check("wr addr",   {20'b0, mem_addr},   32'h123);
        check("wr wdata",  {24'b0, mem_wdata},  32'hA5);
        exp_q.push_back(8'hA5);
        step();
        m0_we = 1'b0;
        @(negedge clk);
        check("rd memreq", {31'b0, mem_memreq}, 32'd1);
        check("rd we",     {31'b0, mem_we},     32'd0);
        check("rd rv0 early", {31'b0, m0_rvalid}, 32'd0);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("rd rv0", {31'b0, m0_rvalid}, 32'd1);
        check("rd rv1", {31'b0, m1_rvalid}, 32'd0);
        if (exp_q.size() > 0) check("rd rdata", {24'b0, m0_rdata}, {24'b0, exp_q.pop_front()});
        step();
        @(negedge clk);
        check("rd rv0 one cycle", {31'b0, m0_rvalid}, 32'd0);

        // Lock holds the bus past the burst cap; dropping it hands over next edge
        do_reset();
        idle_inputs();
        m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("lock t%0d", i), {29'b0, m0_gnt, m1_gnt, mem_memreq}, 32'b101);
            step();
        end
        m0_lock = 1'b0;
        @(negedge clk);
        check("unlock last m0", {29'b0, m0_gnt, m1_gnt, mem_memreq}, 32'b101);
        step();
        @(negedge clk);
        check("unlock handover", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        check("unlock m1 addr", {20'b0, mem_addr}, 32'h020);

        // Reset in the middle of an m1 read transfer suppresses its rvalid
        do_reset();
        idle_inputs();
        m1_req = 1'b1;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rstrd gnt1",   {31'b0, m1_gnt},     32'd1);
        check("rstrd memreq", {31'b0, mem_memreq}, 32'd0);
        step();
        reset  = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        check("rstrd rv1",  {31'b0, m1_rvalid},      32'd0);
        check("rstrd gnts", {30'b0, m0_gnt, m1_gnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
